// File: rtl/uart_rx_fifo_buff.sv
// Receive FIFO between the UART receiver and the host, first-word fall-through.
// Ports: clk, reset (sync, active-high); set_flag/d_in write side; clr_flag pop;
// flush, clr_overrun controls; d_out head word, flag, full, almost_full,
// overrun (sticky), count status.
module uart_rx_fifo_buff #(
    parameter int W        = 8,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            set_flag,
    input  logic [W-1:0]    d_in,
    input  logic            clr_flag,
    input  logic            flush,
    input  logic            clr_overrun,
    output logic [W-1:0]    d_out,
    output logic            flag,
    output logic            full,
    output logic            almost_full,
    output logic            overrun,
    output logic [ADDR_W:0] count
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);

    logic [W-1:0]      r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overrun;

    logic w_empty;
    logic w_full;
    logic w_do_wr;
    logic w_do_rd;
    logic w_ovr_set;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);

    // A pop frees the head slot in the same edge, so a write into a full
    // FIFO is accepted when paired with a read.
    assign w_do_wr   = set_flag && (!w_full || clr_flag) && !flush;
    assign w_do_rd   = clr_flag && !w_empty && !flush;
    assign w_ovr_set = set_flag && w_full && !clr_flag && !flush;

    always_ff @(posedge clk) begin
        if (w_do_wr && !reset) begin
            r_mem[r_wr_ptr] <= d_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_wr && !w_do_rd) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_rd && !w_do_wr) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Set wins over clear when both happen in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_set) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign d_out       = w_empty ? '0 : r_mem[r_rd_ptr];
    assign flag        = !w_empty;
    assign full        = w_full;
    assign almost_full = (r_count >= AF_C);
    assign overrun     = r_overrun;
    assign count       = r_count;

endmodule

// File: tb/tb_uart_rx_fifo_buff.sv
// Scoreboard bench for uart_rx_fifo_buff: stimulus pushes expected words,
// a negedge monitor pops and compares whenever a pop is presented.
module tb_uart_rx_fifo_buff;

    logic       clk = 1'b0;
    logic       reset;
    logic       set_flag;
    logic [7:0] d_in;
    logic       clr_flag;
    logic       flush;
    logic       clr_overrun;
    logic [7:0] d_out;
    logic       flag;
    logic       full;
    logic       almost_full;
    logic       overrun;
    logic [4:0] count;

    int n_pass = 0;
    int n_total = 0;
    logic [7:0] exp_q [$];

    uart_rx_fifo_buff #(.W(8), .ADDR_W(4), .AF_LEVEL(12)) dut (
        .clk         (clk),
        .reset       (reset),
        .set_flag    (set_flag),
        .d_in        (d_in),
        .clr_flag    (clr_flag),
        .flush       (flush),
        .clr_overrun (clr_overrun),
        .d_out       (d_out),
        .flag        (flag),
        .full        (full),
        .almost_full (almost_full),
        .overrun     (overrun),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: a pop is presented when clr_flag is high with data available.
    always @(negedge clk) begin
        if (!reset && !flush && clr_flag && flag) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 1, 0);
            end else begin
                chk("pop_data", int'(d_out), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input bit accept);
        set_flag = 1'b1;
        d_in = d;
        if (accept) exp_q.push_back(d);
        tick();
        set_flag = 1'b0;
    endtask

    task automatic rd();
        clr_flag = 1'b1;
        tick();
        clr_flag = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        exp_q.delete();
        tick();
        flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_flag = 1'b0;
        d_in = '0;
        clr_flag = 1'b0;
        flush = 1'b0;
        clr_overrun = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_count", int'(count), 0);
        chk("rst_flag", int'(flag), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_af", int'(almost_full), 0);
        chk("rst_ovr", int'(overrun), 0);
        chk("rst_dout", int'(d_out), 0);

        // 1: three words
        wr(8'h41, 1);
        chk("t1_flag_first", int'(flag), 1);
        chk("t1_dout_first", int'(d_out), 'h41);
        wr(8'h42, 1);
        wr(8'h43, 1);
        chk("t1_count", int'(count), 3);
        chk("t1_flag", int'(flag), 1);
        chk("t1_dout", int'(d_out), 'h41);
        rd();
        chk("t1_dout_after_rd", int'(d_out), 'h42);
        rd();
        rd();
        chk("t1_flag_empty", int'(flag), 0);
        chk("t1_dout_empty", int'(d_out), 0);

        // 2: fill to 16, drop 17th
        for (int i = 0; i < 16; i++) begin
            wr(8'(i), 1);
            chk("t2_count", int'(count), i + 1);
            chk("t2_af", int'(almost_full), (i + 1 >= 12) ? 1 : 0);
        end
        chk("t2_full", int'(full), 1);
        wr(8'hFF, 0);
        chk("t2_ovr", int'(overrun), 1);
        chk("t2_count_drop", int'(count), 16);

        // 3: full, simultaneous write+read
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("t3_ovr_clr", int'(overrun), 0);
        clr_flag = 1'b1;
        wr(8'hAA, 1);
        clr_flag = 1'b0;
        chk("t3_count", int'(count), 16);
        chk("t3_ovr", int'(overrun), 0);
        for (int i = 0; i < 16; i++) rd();
        chk("t3_empty", int'(flag), 0);
        chk("t3_q", exp_q.size(), 0);

        // 4: empty, simultaneous write+read
        clr_flag = 1'b1;
        wr(8'h55, 1);
        clr_flag = 1'b0;
        chk("t4_count", int'(count), 1);
        chk("t4_dout", int'(d_out), 'h55);
        rd();
        rd();
        chk("t4_count_empty_rd", int'(count), 0);
        chk("t4_flag_empty_rd", int'(flag), 0);

        // 5: streaming 40 words, pointers wrap
        for (int i = 0; i < 40; i++) begin
            clr_flag = (i >= 5);
            wr(8'(8'h80 + i), 1);
            chk("t5_count", int'(count), (i + 1 < 5) ? i + 1 : 5);
        end
        clr_flag = 1'b0;
        for (int i = 0; i < 5; i++) rd();
        chk("t5_q", exp_q.size(), 0);
        chk("t5_flag", int'(flag), 0);

        // 6: flush, clr_overrun, reset mid-operation
        for (int i = 0; i < 16; i++) wr(8'(8'h10 + i), 1);
        wr(8'hEE, 0);
        chk("t6_ovr_set", int'(overrun), 1);
        do_flush();
        for (int i = 0; i < 5; i++) wr(8'(8'h60 + i), 1);
        chk("t6_count5", int'(count), 5);
        chk("t6_ovr5", int'(overrun), 1);
        do_flush();
        chk("t6_flush_count", int'(count), 0);
        chk("t6_flush_flag", int'(flag), 0);
        chk("t6_flush_ovr", int'(overrun), 1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("t6_clr_ovr", int'(overrun), 0);
        for (int i = 0; i < 7; i++) wr(8'(8'h70 + i), 1);
        chk("t6_count7", int'(count), 7);
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        chk("t6_rst_count", int'(count), 0);
        chk("t6_rst_flag", int'(flag), 0);
        chk("t6_rst_dout", int'(d_out), 0);
        chk("t6_rst_full", int'(full), 0);
        chk("t6_rst_af", int'(almost_full), 0);
        wr(8'h99, 1);
        chk("t6_post_rst_dout", int'(d_out), 'h99);
        rd();
        chk("t6_final_q", exp_q.size(), 0);
        chk("t6_final_flag", int'(flag), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
